// File: rtl/wb_writer_pkg.sv
// Shared types and encodings for the writeback stage: load size/select codes
// and the queued register-file write entry.
package wb_writer_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RF_AW = 5;

    localparam logic [1:0] LD_BYTE = 2'd0;
    localparam logic [1:0] LD_HALF = 2'd1;
    localparam logic [1:0] LD_WORD = 2'd2;

    localparam logic SEL_ALU  = 1'b0;
    localparam logic SEL_LOAD = 1'b1;

    typedef struct packed {
        logic             we;
        logic [RF_AW-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_writer_ld_format.sv
// Combinational load formatter: byte/half/word lane select from an aligned
// memory word, then sign or zero extension.
module ld_format
    import wb_writer_pkg::*;
(
    input  logic [XLEN-1:0] mem_i,
    input  logic [1:0]      size_i,
    input  logic            uns_i,
    input  logic [1:0]      off_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        byte_s = mem_i[7:0];
        case (off_i)
            2'd0:    byte_s = mem_i[7:0];
            2'd1:    byte_s = mem_i[15:8];
            2'd2:    byte_s = mem_i[23:16];
            default: byte_s = mem_i[31:24];
        endcase
        half_s = off_i[1] ? mem_i[31:16] : mem_i[15:0];

        data_o = mem_i;
        case (size_i)
            LD_BYTE: data_o = uns_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            LD_HALF: data_o = uns_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            default: data_o = mem_i;
        endcase
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: formats MEM results, queues them in order, drains one
// register-file write per granted cycle and offers bypass lookup on pending writes.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_we,
    input  logic [4:0]       in_rd,
    input  logic             in_sel,
    input  logic [31:0]      in_alu,
    input  logic [31:0]      in_mem,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_uns,
    input  logic [1:0]       in_off,
    input  logic             rf_gnt,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    input  logic [4:0]       fwd_addr1,
    input  logic [4:0]       fwd_addr2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [31:0]      fwd_data1,
    output logic [31:0]      fwd_data2,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    wb_entry_t        ent_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, idx;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [XLEN-1:0]  ld_data;
    wb_entry_t        new_ent, head;
    logic             enq, pop, nonempty;

    ld_format u_ld_format (
        .mem_i  (in_mem),
        .size_i (in_ld_size),
        .uns_i  (in_ld_uns),
        .off_i  (in_off),
        .data_o (ld_data)
    );

    assign nonempty = (count_q != '0);
    assign head     = ent_q[rd_ptr_q];
    assign in_ready = (count_q < CW'(DEPTH));
    assign enq      = rstd && in_valid && in_ready;
    // Entries without a register write retire without waiting for the port.
    assign pop      = rstd && nonempty && (rf_gnt || !head.we);

    assign new_ent.we   = in_we && (in_rd != 5'd0);
    assign new_ent.rd   = in_rd;
    assign new_ent.data = (in_sel == SEL_LOAD) ? ld_data : in_alu;

    assign rf_we    = rstd && nonempty && head.we && rf_gnt;
    assign rf_waddr = nonempty ? head.rd : 5'd0;
    assign rf_wdata = nonempty ? head.data : 32'd0;
    assign retired  = retired_q;

    always_comb begin
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d  = wr_ptr_q + PTR_W'(enq);
        retired_d = pop ? retired_q + CNT_W'(1) : retired_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            retired_q <= '0;
        end else begin
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            retired_q <= retired_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) ent_q[wr_ptr_q] <= new_ent;
    end

    // Oldest-to-youngest walk; later matches overwrite, so the youngest wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CW'(i) < count_q) && ent_q[idx].we) begin
                if ((fwd_addr1 != 5'd0) && (ent_q[idx].rd == fwd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_q[idx].data;
                end
                if ((fwd_addr2 != 5'd0) && (ent_q[idx].rd == fwd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_q[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: table of load/ALU formatting vectors plus
// hand-written sequences for backpressure, non-writing entries, bypass and reset.
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        rstd, in_valid, in_ready, in_we, in_sel, in_ld_uns, rf_gnt;
    logic [4:0]  in_rd, rf_waddr, fwd_addr1, fwd_addr2;
    logic [31:0] in_alu, in_mem, rf_wdata, fwd_data1, fwd_data2;
    logic [1:0]  in_ld_size, in_off;
    logic        rf_we, fwd_hit1, fwd_hit2;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ret;

    always #5 clk = ~clk;

    wb_writer #(.DEPTH(2), .CNT_W(32)) dut (
        .clk(clk), .rstd(rstd),
        .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_rd(in_rd),
        .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem), .in_ld_size(in_ld_size),
        .in_ld_uns(in_ld_uns), .in_off(in_off), .rf_gnt(rf_gnt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .retired(retired)
    );

    typedef struct {
        string       name;
        logic        sel;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result; it is accepted at the next posedge (caller ensures space).
    task automatic push(input logic [4:0] rd, input logic we, input logic sel,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic [1:0] size, input logic uns, input logic [1:0] off);
        in_valid = 1'b1; in_rd = rd; in_we = we; in_sel = sel; in_alu = alu;
        in_mem = mem; in_ld_size = size; in_ld_uns = uns; in_off = off;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"ld_b1_s",   1'b1, 2'd0, 1'b0, 2'd1, 32'h0, 32'h80FF7F01, 5'd1, 32'h0000007F};
        vecs[1] = '{"ld_b2_s",   1'b1, 2'd0, 1'b0, 2'd2, 32'h0, 32'h80FF7F01, 5'd2, 32'hFFFFFFFF};
        vecs[2] = '{"ld_b3_u",   1'b1, 2'd0, 1'b1, 2'd3, 32'h0, 32'h80FF7F01, 5'd3, 32'h00000080};
        vecs[3] = '{"ld_b3_s",   1'b1, 2'd0, 1'b0, 2'd3, 32'h0, 32'h80FF7F01, 5'd4, 32'hFFFFFF80};
        vecs[4] = '{"ld_b0_s",   1'b1, 2'd0, 1'b0, 2'd0, 32'h0, 32'h80FF7F01, 5'd5, 32'h00000001};
        vecs[5] = '{"ld_h2_s",   1'b1, 2'd1, 1'b0, 2'd2, 32'h0, 32'h80FF7F01, 5'd6, 32'hFFFF80FF};
        vecs[6] = '{"ld_h3_s",   1'b1, 2'd1, 1'b0, 2'd3, 32'h0, 32'h80FF7F01, 5'd7, 32'hFFFF80FF};
        vecs[7] = '{"ld_h0_u",   1'b1, 2'd1, 1'b1, 2'd0, 32'h0, 32'h80FF7F01, 5'd8, 32'h00007F01};
        vecs[8] = '{"ld_w_off3", 1'b1, 2'd3, 1'b0, 2'd3, 32'h0, 32'h80FF7F01, 5'd9, 32'h80FF7F01};
        vecs[9] = '{"alu_sel",   1'b0, 2'd0, 1'b0, 2'd1, 32'hDEADBEEF, 32'h80FF7F01, 5'd31, 32'hDEADBEEF};

        rstd = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_rd = '0; in_sel = 1'b0;
        in_alu = '0; in_mem = '0; in_ld_size = '0; in_ld_uns = 1'b0; in_off = '0;
        rf_gnt = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;
        tick(); tick();
        rstd = 1'b1;
        exp_ret = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_hit1", 32'(fwd_hit1), 32'd0);
        chk("rst_hit2", 32'(fwd_hit2), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Single ALU result, two-edge latency
        rf_gnt = 1'b1;
        in_valid = 1'b1; in_rd = 5'd5; in_we = 1'b1; in_sel = 1'b0; in_alu = 32'h12345678;
        @(negedge clk);
        chk("alu_no_passthru", 32'(rf_we), 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("alu_rf_we", 32'(rf_we), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata, 32'h12345678);
        tick();
        exp_ret = exp_ret + 1;
        @(negedge clk);
        chk("alu_retired", retired, exp_ret);
        chk("alu_empty_we", 32'(rf_we), 32'd0);
        tick();

        // Formatting vectors
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].rd, 1'b1, vecs[i].sel, vecs[i].alu, vecs[i].mem,
                 vecs[i].size, vecs[i].uns, vecs[i].off);
            @(negedge clk);
            chk({vecs[i].name, "_we"}, 32'(rf_we), 32'd1);
            chk({vecs[i].name, "_addr"}, 32'(rf_waddr), 32'(vecs[i].rd));
            chk(vecs[i].name, rf_wdata, vecs[i].exp);
            tick();
            exp_ret = exp_ret + 1;
        end
        @(negedge clk);
        chk("vec_retired", retired, exp_ret);
        tick();

        // Backpressure: fill with no grant, third result refused
        rf_gnt = 1'b0;
        push(5'd1, 1'b1, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 2'd0);
        push(5'd2, 1'b1, 1'b0, 32'h22, 32'h0, 2'd0, 1'b0, 2'd0);
        in_valid = 1'b1; in_rd = 5'd3; in_alu = 32'h33;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_hold_we", 32'(rf_we), 32'd0);
        chk("full_head_addr", 32'(rf_waddr), 32'd1);
        tick();
        rf_gnt = 1'b1;
        @(negedge clk);
        chk("drain1_we", 32'(rf_we), 32'd1);
        chk("drain1_data", rf_wdata, 32'h11);
        chk("drain1_ready", 32'(in_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("drain2_ready", 32'(in_ready), 32'd1);
        chk("drain2_we", 32'(rf_we), 32'd1);
        chk("drain2_addr", 32'(rf_waddr), 32'd2);
        chk("drain2_data", rf_wdata, 32'h22);
        tick();
        exp_ret = exp_ret + 2;
        @(negedge clk);
        chk("drain_empty_we", 32'(rf_we), 32'd0);
        chk("drain_retired", retired, exp_ret);
        tick();

        // Non-writing entries retire without a grant
        rf_gnt = 1'b0;
        push(5'd0, 1'b1, 1'b0, 32'hAAAA, 32'h0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        chk("nw_rd0_we", 32'(rf_we), 32'd0);
        tick();
        push(5'd9, 1'b0, 1'b0, 32'hBBBB, 32'h0, 2'd0, 1'b0, 2'd0);
        @(negedge clk);
        chk("nw_we0_we", 32'(rf_we), 32'd0);
        chk("nw_we0_addr", 32'(rf_waddr), 32'd9);
        tick();
        exp_ret = exp_ret + 2;
        @(negedge clk);
        chk("nw_retired", retired, exp_ret);
        chk("nw_empty_ready", 32'(in_ready), 32'd1);
        tick();

        // Bypass: youngest of two pending writes to x7
        push(5'd7, 1'b1, 1'b0, 32'hA, 32'h0, 2'd0, 1'b0, 2'd0);
        push(5'd7, 1'b1, 1'b0, 32'hB, 32'h0, 2'd0, 1'b0, 2'd0);
        fwd_addr1 = 5'd7; fwd_addr2 = 5'd0;
        @(negedge clk);
        chk("fwd1_hit", 32'(fwd_hit1), 32'd1);
        chk("fwd1_data", fwd_data1, 32'hB);
        chk("fwd2_zero_hit", 32'(fwd_hit2), 32'd0);
        chk("fwd2_zero_data", fwd_data2, 32'd0);
        #1 fwd_addr2 = 5'd3;
        #1 chk("fwd2_miss", 32'(fwd_hit2), 32'd0);
        tick();
        rf_gnt = 1'b1;
        @(negedge clk);
        chk("fwd_wr_data", rf_wdata, 32'hA);
        chk("fwd_during_wr", fwd_data1, 32'hB);
        tick();
        @(negedge clk);
        chk("fwd_last_hit", 32'(fwd_hit1), 32'd1);
        chk("fwd_last_data", fwd_data1, 32'hB);
        tick();
        exp_ret = exp_ret + 2;
        @(negedge clk);
        chk("fwd_empty_hit", 32'(fwd_hit1), 32'd0);
        chk("fwd_retired", retired, exp_ret);
        tick();

        // Reset with two queued entries discards them
        rf_gnt = 1'b0;
        push(5'd4, 1'b1, 1'b0, 32'h44, 32'h0, 2'd0, 1'b0, 2'd0);
        push(5'd6, 1'b1, 1'b0, 32'h66, 32'h0, 2'd0, 1'b0, 2'd0);
        fwd_addr1 = 5'd4;
        rstd = 1'b0; rf_gnt = 1'b1;
        @(negedge clk);
        chk("midrst_no_write", 32'(rf_we), 32'd0);
        tick();
        rstd = 1'b1;
        @(negedge clk);
        chk("midrst_we", 32'(rf_we), 32'd0);
        chk("midrst_retired", retired, 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_hit", 32'(fwd_hit1), 32'd0);
        chk("midrst_waddr", 32'(rf_waddr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("midrst_idle_we", 32'(rf_we), 32'd0);
        end
        chk("midrst_idle_ret", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
